// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family and its adapters.
// Keep in step with the FIFO block itself.
package fifo_pkg;

   localparam int FIFO_DEFAULT_WIDTH = 16;

   // Occupancy of small output buffers (0..2 entries).
   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer behind the FIFO read port: push at tail, pop at head.
// Push and pop in the same cycle keep occupancy and ordering intact.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output occ_t             occ,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   occ_t             occ_q, occ_d;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
      // With both entries full, a push lands on the head slot being popped this same edge.
      if (push) begin
         mem_d[tail_q] = push_data;
         tail_d        = ~tail_q;
      end
      if (pop) begin
         head_d = ~head_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         occ_q    <= OCC_EMPTY;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         head_q   <= head_d;
         tail_q   <= tail_d;
         occ_q    <= occ_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: issues FIFO reads, absorbs the one-cycle read latency, and
// presents words on a valid/ready stream. FIFO_READER_STATS_EN adds xfer_cnt.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fifo_rd_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic             idle
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [31:0]      xfer_cnt
`endif
);

   // Stream handshake: a beat transfers on a clock edge where m_valid && m_ready.
   // Once m_valid rises, m_valid and m_data hold until that transfer; neither
   // depends combinationally on m_ready. m_ready may depend on m_valid.

   occ_t       occ;
   logic       pop;
   logic       in_flight_q, in_flight_d;
   logic [2:0] demand;

   assign pop = m_valid && m_ready;

   // Slots committed after this edge; m_ready feeds this so reads continue at full rate.
   always_comb begin
      demand      = 3'(occ) + 3'(in_flight_q) - 3'(pop);
      fifo_rd_en  = rst_n && !fifo_empty && (demand < 3'(OCC_FULL));
      in_flight_d = fifo_rd_en;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_flight_q <= 1'b0;
      end else begin
         in_flight_q <= in_flight_d;
      end
   end

   fifo_rd_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_flight_q),
      .push_data (fifo_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (m_data)
   );

   assign m_valid = (occ != OCC_EMPTY);
   assign idle    = (occ == OCC_EMPTY) && !in_flight_q;

`ifdef FIFO_READER_STATS_EN
   logic [31:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q + 32'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO with one-cycle read
// latency, a per-cycle monitor/scoreboard, a reset/single-word vector table and
// multi-cycle sequences for streaming, backpressure, mid-burst reset and stats.
module tb_fifo_stream_reader;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         fifo_rd_en;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_data = '0;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_ready = 1'b1;
   logic         idle;
`ifdef FIFO_READER_STATS_EN
   logic [31:0]  xfer_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];

   logic         rd_en_s = 1'b0;
   logic         rst_s = 1'b0;
   logic         stall_valid = 1'b0;
   logic [W-1:0] stall_data = '0;

   fifo_stream_reader #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_rd_en (fifo_rd_en),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .idle       (idle)
`ifdef FIFO_READER_STATS_EN
      ,
      .xfer_cnt   (xfer_cnt)
`endif
   );

   // Clock/reset block: reset is driven from the stimulus process.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle monitor at the negedge, then the FIFO model and input window just after posedge.
   task automatic next_cycle();
      @(negedge clk);
      if (rst_n) begin
         check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
         check("occ_le_2", 32'(dut.u_skid.occ_q <= 2'd2), 32'd1);
         if (stall_valid) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(stall_data));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 32'(m_data), 32'hdead_beef);
            else check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
         end
         stall_valid = m_valid && !m_ready;
         stall_data  = m_data;
      end else begin
         stall_valid = 1'b0;
      end
      rd_en_s = fifo_rd_en;
      rst_s   = rst_n;
      @(posedge clk);
      #1;
      if (!rst_s) fifo_data = '0;
      else if (rd_en_s && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic load_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         next_cycle();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   typedef struct {
      logic         rst_n;
      logic         m_ready;
      logic         exp_rd_en;
      logic         exp_valid;
      logic [W-1:0] exp_data;
      logic         chk_data;
      logic         exp_idle;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic bp_pat[4];
      int   waited;
      int   k;

      // Reset held three cycles with a word already in the FIFO, then one word out.
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

      load_word(16'hA5A5);
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         rst_n   = vecs[i].rst_n;
         m_ready = vecs[i].m_ready;
         #2;
         check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
         check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].chk_data)
            check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].exp_idle));
      end
      check("single_drained", 32'(exp_q.size()), 32'd0);

      // Streaming: 16 back-to-back beats once the first arrives.
      for (int i = 0; i < 16; i++) load_word(W'(i));
      m_ready = 1'b1;
      waited  = 0;
      next_cycle();
      #2;
      while (!m_valid && waited < 10) begin
         next_cycle();
         #2;
         waited++;
      end
      check("stream_first_valid", 32'(m_valid), 32'd1);
      for (int i = 1; i < 16; i++) begin
         next_cycle();
         #2;
         check($sformatf("stream_beat%0d", i), 32'(m_valid), 32'd1);
      end
      next_cycle();
      #2;
      check("stream_end_valid", 32'(m_valid), 32'd0);
      check("stream_end_idle", 32'(idle), 32'd1);
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure: m_ready pattern 1,0,0,1.
      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) load_word(16'h0100 + W'(i * 3));
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         next_cycle();
         m_ready = bp_pat[k % 4];
         k++;
      end
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      m_ready = 1'b1;
      next_cycle();
      next_cycle();
      #2;
      check("bp_idle", 32'(idle), 32'd1);

      // Reset mid-burst with the buffer full and the FIFO still holding words.
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) load_word(16'hBEE0 + W'(i));
      waited = 0;
      while (!m_valid && waited < 10) begin
         next_cycle();
         #2;
         waited++;
      end
      check("mid_valid_before_reset", 32'(m_valid), 32'd1);
      next_cycle();
      next_cycle();
      #2;
      check("mid_full_before_reset", 32'(fifo_rd_en), 32'd0);
      next_cycle();
      rst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      next_cycle();
      rst_n = 1'b1;
      #2;
      check("mid_valid_after_reset", 32'(m_valid), 32'd0);
      check("mid_data_after_reset", 32'(m_data), 32'd0);
      check("mid_idle_after_reset", 32'(idle), 32'd1);
      load_word(16'h1234);
      m_ready = 1'b1;
      drain("mid_fresh_word", 20);
      next_cycle();
      #2;
      check("mid_final_idle", 32'(idle), 32'd1);

`ifdef FIFO_READER_STATS_EN
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      #2;
      check("stats_reset", xfer_cnt, 32'd0);
      for (int i = 0; i < 10; i++) load_word(16'h0C00 + W'(i));
      drain("stats_drained", 40);
      next_cycle();
      #2;
      check("stats_ten", xfer_cnt, 32'd10);
      force dut.xfer_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.xfer_cnt_q;
      #1;
      check("stats_preset", xfer_cnt, 32'hFFFF_FFFF);
      load_word(16'h0FFF);
      drain("stats_wrap_drained", 20);
      next_cycle();
      #2;
      check("stats_wrap", xfer_cnt, 32'd0);
`endif

      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
